// File: rtl/uart_tx.sv
// uart_tx: start/data/stop serial transmitter with a configurable bit period and data width.
// The serial line, busy and done are all driven directly from flip-flops.
module uart_tx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_WIDTH) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ZERO = BAUD_W'(0);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0]  IDX_ZERO  = IDX_W'(0);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [DATA_WIDTH-1:0] SHIFT_ZERO = DATA_WIDTH'(0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [BAUD_W-1:0]       baud_q, baud_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    baud_last_s;
    logic                    idx_last_s;

    assign baud_last_s = (baud_q == BAUD_LAST);
    assign idx_last_s  = (idx_q == IDX_LAST);

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= BAUD_ZERO;
            idx_q   <= IDX_ZERO;
            shift_q <= SHIFT_ZERO;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic; the shift register LSB is always the bit on the line
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_d = BAUD_ZERO;
                idx_d  = IDX_ZERO;
                if (start) begin
                    shift_d = data_in;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end

            ST_START: begin
                busy_d = 1'b1;
                if (baud_last_s) begin
                    baud_d  = BAUD_ZERO;
                    idx_d   = IDX_ZERO;
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d  = baud_q + BAUD_ONE;
                    tx_d    = 1'b0;
                end
            end

            ST_DATA: begin
                busy_d = 1'b1;
                if (baud_last_s) begin
                    baud_d = BAUD_ZERO;
                    if (idx_last_s) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // Advance to the next bit: it is already sitting one place above the LSB
                        idx_d   = idx_q + IDX_ONE;
                        shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                    tx_d   = shift_q[0];
                end
            end

            ST_STOP: begin
                tx_d = 1'b1;
                if (baud_last_s) begin
                    baud_d  = BAUD_ZERO;
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    baud_d  = baud_q + BAUD_ONE;
                    busy_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                baud_d  = BAUD_ZERO;
                idx_d   = IDX_ZERO;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and randomized checks of uart_tx against a frame-position model,
// using one instance at 4 clocks/bit x 8 bits and one at 2 clocks/bit x 7 bits.
module tb_uart_tx;

    localparam int C0 = 4;
    localparam int W0 = 8;
    localparam int C1 = 2;
    localparam int W1 = 7;

    logic       clk = 1'b0;
    logic       rst0, start0, tx0, busy0, done0;
    logic [7:0] data0;
    logic       rst1, start1, tx1, busy1, done1;
    logic [6:0] data1;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    uart_tx #(.CLKS_PER_BIT(C0), .DATA_WIDTH(W0)) dut0 (
        .clk(clk), .rst(rst0), .start(start0), .data_in(data0),
        .tx(tx0), .busy(busy0), .done(done0)
    );

    uart_tx #(.CLKS_PER_BIT(C1), .DATA_WIDTH(W1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .data_in(data1),
        .tx(tx1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    // Expected line level t cycles after the accepting edge: slot 0 start, 1..dw data LSB first, then stop/idle
    function automatic logic model_tx(input logic [8:0] d, input int dw, input int cpb, input int t);
        int         slot;
        logic [8:0] sh;
        if (t < 1 || t > (dw + 2) * cpb) return 1'b1;
        slot = (t - 1) / cpb;
        if (slot == 0) return 1'b0;
        if (slot <= dw) begin
            sh = d >> (slot - 1);
            return sh[0];
        end
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input int sel, input int t, input logic obs, input logic exp);
        assert_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s (dut%0d, t=%0d): observed %b expected %b", tag, sel, t, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic r, input logic s, input logic [8:0] d);
        if (sel == 0) begin
            rst0 = r; start0 = s; data0 = d[7:0];
        end else begin
            rst1 = r; start1 = s; data1 = d[6:0];
        end
    endtask

    task automatic check_at(input int sel, input logic [8:0] d, input int t);
        int   cpb, dw, n;
        logic otx, obusy, odone;
        cpb = (sel == 0) ? C0 : C1;
        dw  = (sel == 0) ? W0 : W1;
        n   = (dw + 2) * cpb;
        otx   = (sel == 0) ? tx0   : tx1;
        obusy = (sel == 0) ? busy0 : busy1;
        odone = (sel == 0) ? done0 : done1;
        chk("tx",   sel, t, otx,   model_tx(d, dw, cpb, t));
        chk("busy", sel, t, obusy, (t >= 1 && t <= n) ? 1'b1 : 1'b0);
        chk("done", sel, t, odone, (t == n + 1) ? 1'b1 : 1'b0);
    endtask

    // noise: 0 quiet, 1 fixed start pulses plus data change, 2 random start/data while busy
    task automatic run_frame(input int sel, input logic [8:0] d, input int last_t, input int noise);
        int         n;
        logic       ns;
        logic [8:0] nd;
        n = (sel == 0) ? (W0 + 2) * C0 : (W1 + 2) * C1;
        for (int t = 1; t <= last_t; t++) begin
            @(negedge clk);
            check_at(sel, d, t);
            ns = 1'b0;
            nd = d;
            if (noise == 1 && t <= n) begin
                ns = (t == 5 || t == 17 || t == 33) ? 1'b1 : 1'b0;
                nd = (t >= 6) ? 9'h0FF : d;
            end else if (noise == 2 && t <= n) begin
                ns = 1'($urandom_range(0, 1));
                nd = 9'($urandom);
            end else begin
                ns = 1'b0;
            end
            drive(sel, 1'b0, ns, nd);
        end
    endtask

    task automatic idle(input int sel, input logic r, input int cycles);
        logic otx, obusy, odone;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            otx   = (sel == 0) ? tx0   : tx1;
            obusy = (sel == 0) ? busy0 : busy1;
            odone = (sel == 0) ? done0 : done1;
            chk("idle_tx",   sel, i, otx,   1'b1);
            chk("idle_busy", sel, i, obusy, 1'b0);
            chk("idle_done", sel, i, odone, 1'b0);
            drive(sel, r, 1'b0, 9'h000);
        end
    endtask

    initial begin
        logic [8:0] d;
        int         gap;

        drive(0, 1'b1, 1'b0, 9'h000);
        drive(1, 1'b1, 1'b0, 9'h000);

        // Reset then quiet idle
        idle(0, 1'b1, 2);
        idle(0, 1'b0, 20);

        // Basic frame
        drive(0, 1'b0, 1'b1, 9'h0A5);
        run_frame(0, 9'h0A5, (W0 + 2) * C0 + 1, 0);
        idle(0, 1'b0, 3);

        // Start pulses and data change during a frame are ignored
        drive(0, 1'b0, 1'b1, 9'h03C);
        run_frame(0, 9'h03C, (W0 + 2) * C0 + 1, 1);
        idle(0, 1'b0, 30);

        // Back-to-back: start accepted in the done cycle
        drive(0, 1'b0, 1'b1, 9'h001);
        run_frame(0, 9'h001, (W0 + 2) * C0 + 1, 0);
        drive(0, 1'b0, 1'b1, 9'h080);
        run_frame(0, 9'h080, (W0 + 2) * C0 + 1, 0);
        idle(0, 1'b0, 2);

        // Reset during the 4th data bit aborts the frame without a done strobe
        drive(0, 1'b0, 1'b1, 9'h055);
        run_frame(0, 9'h055, 18, 0);
        drive(0, 1'b1, 1'b0, 9'h000);
        idle(0, 1'b1, 1);
        idle(0, 1'b0, 50);
        d = 9'($urandom_range(0, 255));
        drive(0, 1'b0, 1'b1, d);
        run_frame(0, d, (W0 + 2) * C0 + 1, 0);

        // Randomized frames with busy-time noise and random gaps (zero gap = back-to-back)
        for (int i = 0; i < 8; i++) begin
            d = 9'($urandom_range(0, 255));
            drive(0, 1'b0, 1'b1, d);
            run_frame(0, d, (W0 + 2) * C0 + 1, 2);
            gap = $urandom_range(0, 3);
            if (gap > 0) idle(0, 1'b0, gap);
        end
        idle(0, 1'b0, 3);

        // Second parameter set
        drive(1, 1'b0, 1'b0, 9'h000);
        idle(1, 1'b0, 4);
        drive(1, 1'b0, 1'b1, 9'h05A);
        run_frame(1, 9'h05A, (W1 + 2) * C1 + 1, 0);
        idle(1, 1'b0, 3);
        for (int i = 0; i < 6; i++) begin
            d = 9'($urandom_range(0, 127));
            drive(1, 1'b0, 1'b1, d);
            run_frame(1, d, (W1 + 2) * C1 + 1, 2);
            gap = $urandom_range(0, 2);
            if (gap > 0) idle(1, 1'b0, gap);
        end
        idle(1, 1'b0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
